// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the RR-stage hazard scoreboard.
package tartaruga_pkg;

    localparam int SB_DEPTH_DEFAULT = 5;

    // Stored destination width; wide enough for any REG_W this pipeline uses (REG_W <= 8).
    localparam int SB_RD_W = 8;

    // fwd_sel value meaning "read the register file".
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               we;
        logic               is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_sb_match.sv
// Per-source lookup: finds the youngest in-flight producer of one source operand
// and reports whether its result is not yet forwardable.
module hazard_sb_match
    import tartaruga_pkg::*;
#(
    parameter int DEPTH    = SB_DEPTH_DEFAULT,
    parameter int REG_W    = 5,
    parameter int LOAD_RDY = 3,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH:1] entries,
    input  logic [REG_W-1:0]    rs,
    input  logic                used,
    output logic [SEL_W-1:0]    sel,
    output logic                not_ready
);

    // Priority encode oldest-to-youngest so the youngest match overwrites older ones.
    always_comb begin
        sel       = SEL_W'(FWD_REGFILE);
        not_ready = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (rs != '0) && entries[k].valid && entries[k].we &&
                (entries[k].rd == SB_RD_W'(rs))) begin
                sel       = SEL_W'(k);
                not_ready = entries[k].is_load && (k < LOAD_RDY);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard tracker beside RR: shift pipe of destinations mirroring EXE..WB,
// forwarding selection per source, load-use stall and a stall counter.
module hazard_scoreboard
    import tartaruga_pkg::*;
#(
    parameter int DEPTH    = SB_DEPTH_DEFAULT,
    parameter int NUM_SRC  = 2,
    parameter int REG_W    = 5,
    parameter int LOAD_RDY = 3,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     issue_valid_i,
    input  logic [REG_W-1:0]         issue_rd_i,
    input  logic                     issue_we_i,
    input  logic                     issue_is_load_i,
    input  logic [NUM_SRC*REG_W-1:0] issue_rs_i,
    input  logic [NUM_SRC-1:0]       issue_rs_used_i,
    input  logic                     hold_i,
    input  logic                     flush_i,
    input  logic [DEPTH-1:0]         kill_mask_i,
    output logic                     issue_ready_o,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic [CNT_W-1:0]         stall_count_o
);

    sb_entry_t [DEPTH:1] entries;
    sb_entry_t [DEPTH:1] entries_nxt;
    logic [NUM_SRC-1:0]  src_not_ready;
    logic                hazard;
    logic                insert;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_sb_match #(
            .DEPTH    (DEPTH),
            .REG_W    (REG_W),
            .LOAD_RDY (LOAD_RDY),
            .SEL_W    (SEL_W)
        ) u_match (
            .entries   (entries),
            .rs        (issue_rs_i[s*REG_W +: REG_W]),
            .used      (issue_rs_used_i[s]),
            .sel       (fwd_sel_o[s*SEL_W +: SEL_W]),
            .not_ready (src_not_ready[s])
        );
    end

    assign hazard        = issue_valid_i && (|src_not_ready);
    assign issue_ready_o = !hold_i && !hazard;
    assign insert        = issue_valid_i && issue_ready_o && !flush_i && issue_we_i;

    // Next pipe contents: kill applies to current entries, then shift or freeze.
    always_comb begin
        entries_nxt = entries;
        if (hold_i) begin
            for (int k = 1; k <= DEPTH; k++) begin
                entries_nxt[k].valid = entries[k].valid && !kill_mask_i[k-1];
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                entries_nxt[k]       = entries[k-1];
                entries_nxt[k].valid = entries[k-1].valid && !kill_mask_i[k-2];
            end
            entries_nxt[1] = '0;
            if (insert) begin
                entries_nxt[1].valid   = 1'b1;
                entries_nxt[1].rd      = SB_RD_W'(issue_rd_i);
                entries_nxt[1].we      = issue_we_i;
                entries_nxt[1].is_load = issue_is_load_i;
            end
        end
    end

    // Entry pipe register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            entries <= '0;
        end else begin
            entries <= entries_nxt;
        end
    end

    // Saturating count of cycles lost to load-use hazards.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_count_o <= '0;
        end else if (hazard && !hold_i && !flush_i && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + 1'b1;
        end
    end

endmodule
